// File: rtl/mdu_pkg.sv
// Shared MDU constants: op encodings, operand width and default latencies.
// The decoder imports this package as well.
package mdu_pkg;

  localparam int unsigned MDU_WIDTH       = 32;
  localparam int unsigned MDU_MULT_CYCLES = 5;
  localparam int unsigned MDU_DIV_CYCLES  = 10;

  typedef enum logic [2:0] {
    MDU_NONE  = 3'd0,
    MDU_MULT  = 3'd1,
    MDU_MULTU = 3'd2,
    MDU_DIV   = 3'd3,
    MDU_DIVU  = 3'd4,
    MDU_MTHI  = 3'd5,
    MDU_MTLO  = 3'd6,
    MDU_RSVD  = 3'd7
  } mdu_op_e;

  function automatic logic is_muldiv(input mdu_op_e op);
    return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational multiply/divide datapath producing the 2*WIDTH {hi,lo} result.
module mdu_calc
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = MDU_WIDTH
) (
  input  mdu_op_e          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi_res,
  output logic [WIDTH-1:0] lo_res,
  output logic             div_by_zero
);

  logic [2*WIDTH-1:0] prod_s, prod_u;
  logic [WIDTH-1:0]   b_safe;
  logic signed [WIDTH-1:0] sa, sb;
  logic [WIDTH-1:0]   q_s, r_s, q_u, r_u;
  logic               ovf;

  // Multiplying sign-extended operands yields the exact signed product in the low 2*WIDTH bits.
  assign prod_s = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
  assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

  assign div_by_zero = (b == '0);
  assign b_safe      = div_by_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : b;
  assign sa          = a;
  assign sb          = b_safe;
  assign ovf         = (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == {WIDTH{1'b1}});

  always_comb begin
    q_s = '0;
    r_s = '0;
    if (ovf) begin
      q_s = a;
      r_s = '0;
    end else begin
      q_s = sa / sb;
      r_s = sa % sb;
    end
  end

  assign q_u = a / b_safe;
  assign r_u = a % b_safe;

  always_comb begin
    hi_res = '0;
    lo_res = '0;
    unique case (op)
      MDU_MULT:  {hi_res, lo_res} = prod_s;
      MDU_MULTU: {hi_res, lo_res} = prod_u;
      MDU_DIV:   begin hi_res = r_s; lo_res = q_s; end
      MDU_DIVU:  begin hi_res = r_u; lo_res = q_u; end
      default:   ;
    endcase
  end

endmodule

// File: rtl/mdu.sv
// E-stage multiply/divide unit: owns HI/LO, models latency with a busy counter.
module mdu
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH       = MDU_WIDTH,
  parameter int unsigned MULT_CYCLES = MDU_MULT_CYCLES,
  parameter int unsigned DIV_CYCLES  = MDU_DIV_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cancel,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned MaxCycles = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  mdu_op_e          op_e;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] phi_q, phi_d, plo_q, plo_d;
  logic             nocommit_q, nocommit_d;
  logic [WIDTH-1:0] hi_res, lo_res;
  logic             div_by_zero;
  logic             accept;

  assign op_e   = mdu_op_e'(op);
  assign busy   = (cnt_q != '0);
  assign hi     = hi_q;
  assign lo     = lo_q;
  assign accept = start && !busy && !cancel;

  mdu_calc #(
    .WIDTH (WIDTH)
  ) u_calc (
    .op          (op_e),
    .a           (A),
    .b           (B),
    .hi_res      (hi_res),
    .lo_res      (lo_res),
    .div_by_zero (div_by_zero)
  );

  always_comb begin
    cnt_d      = cnt_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    phi_d      = phi_q;
    plo_d      = plo_q;
    nocommit_d = nocommit_q;
    if (cancel) begin
      // Cancel beats a same-edge commit and any same-cycle start.
      cnt_d      = '0;
      phi_d      = '0;
      plo_d      = '0;
      nocommit_d = 1'b0;
    end else if (busy) begin
      cnt_d = cnt_q - CntW'(1);
      if ((cnt_q == CntW'(1)) && !nocommit_q) begin
        hi_d = phi_q;
        lo_d = plo_q;
      end
    end else if (accept) begin
      unique case (op_e)
        MDU_MULT, MDU_MULTU: begin
          phi_d      = hi_res;
          plo_d      = lo_res;
          nocommit_d = 1'b0;
          cnt_d      = CntW'(MULT_CYCLES);
        end
        MDU_DIV, MDU_DIVU: begin
          phi_d      = hi_res;
          plo_d      = lo_res;
          nocommit_d = div_by_zero;
          cnt_d      = CntW'(DIV_CYCLES);
        end
        MDU_MTHI: hi_d = A;
        MDU_MTLO: lo_d = A;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      phi_q      <= '0;
      plo_q      <= '0;
      nocommit_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      phi_q      <= phi_d;
      plo_q      <= plo_d;
      nocommit_q <= nocommit_d;
    end
  end

endmodule
